// File: rtl/detect_word_scheduler_if.sv
// Bundle of request/grant, detector drive and result signals for the
// detect_word_scheduler. The scheduler uses the slave view; the word
// producers plus the detector use the master view.
interface detect_word_scheduler_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
);
    logic             req0;
    logic [WIDTH-1:0] data0;
    logic             req1;
    logic [WIDTH-1:0] data1;
    logic             gnt0;
    logic             gnt1;
    logic             det_clr_n;
    logic             det_x;
    logic             det_y;
    logic             busy;
    logic             done;
    logic             done_id;
    logic [CNT_W-1:0] hits;

    modport master (
        output req0, data0, req1, data1, det_y,
        input  gnt0, gnt1, det_clr_n, det_x, busy, done, done_id, hits
    );

    modport slave (
        input  req0, data0, req1, data1, det_y,
        output gnt0, gnt1, det_clr_n, det_x, busy, done, done_id, hits
    );
endinterface

// File: rtl/detect_word_scheduler.sv
// Round-robin scheduler that shares one serial Moore sequence detector
// between two word requesters. Each granted word is shifted LSB-first into
// a freshly cleared detector and the number of bit positions after which
// the detector output was high is reported in hits.
module detect_word_scheduler #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    detect_word_scheduler_if.slave bus
);
    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_SHIFT = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t             state_r;
    logic               last_r;
    logic               id_r;
    logic [WIDTH-1:0]   word_r;
    logic [IDX_W-1:0]   idx_r;
    logic [CNT_W-1:0]   acc_r;
    logic [CNT_W-1:0]   hits_r;
    logic               done_id_r;

    logic               gnt0_s;
    logic               gnt1_s;
    logic               busy_s;
    logic               done_s;
    logic               det_x_s;
    logic               det_clr_n_s;

    // Arbitration: only in IDLE and never while reset is applied; a tie goes
    // to the requester that was not granted last.
    always_comb begin
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
        if ((state_r == ST_IDLE) && reset_n) begin
            if (bus.req0 && bus.req1) begin
                if (last_r) begin
                    gnt0_s = 1'b1;
                end else begin
                    gnt1_s = 1'b1;
                end
            end else if (bus.req0) begin
                gnt0_s = 1'b1;
            end else if (bus.req1) begin
                gnt1_s = 1'b1;
            end else begin
                gnt0_s = 1'b0;
                gnt1_s = 1'b0;
            end
        end else begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end
    end

    // Status and detector drive decoded from the state register; the
    // detector is held in reset outside SHIFT/DRAIN/DONE and during reset.
    always_comb begin
        busy_s      = 1'b1;
        done_s      = 1'b0;
        det_x_s     = 1'b0;
        det_clr_n_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                busy_s = 1'b0;
            end
            ST_CLEAR: begin
                det_clr_n_s = 1'b0;
            end
            ST_SHIFT: begin
                det_x_s     = word_r[idx_r];
                det_clr_n_s = reset_n;
            end
            ST_DRAIN: begin
                det_clr_n_s = reset_n;
            end
            ST_DONE: begin
                done_s      = 1'b1;
                det_clr_n_s = reset_n;
            end
            default: begin
                busy_s = 1'b1;
            end
        endcase
    end

    // Main controller: grant capture, bit shifting, hit accumulation and
    // result registers. Unused state codes fall back to IDLE.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r   <= ST_IDLE;
            last_r    <= 1'b1;
            id_r      <= 1'b0;
            word_r    <= {WIDTH{1'b0}};
            idx_r     <= {IDX_W{1'b0}};
            acc_r     <= {CNT_W{1'b0}};
            hits_r    <= {CNT_W{1'b0}};
            done_id_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (gnt0_s) begin
                        word_r  <= bus.data0;
                        id_r    <= 1'b0;
                        last_r  <= 1'b0;
                        state_r <= ST_CLEAR;
                    end else if (gnt1_s) begin
                        word_r  <= bus.data1;
                        id_r    <= 1'b1;
                        last_r  <= 1'b1;
                        state_r <= ST_CLEAR;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_CLEAR: begin
                    idx_r   <= {IDX_W{1'b0}};
                    acc_r   <= {CNT_W{1'b0}};
                    state_r <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    idx_r <= idx_r + IDX_W'(1);
                    // det_y here reflects the bit shifted in the previous cycle
                    if ((idx_r != {IDX_W{1'b0}}) && bus.det_y) begin
                        acc_r <= acc_r + CNT_W'(1);
                    end else begin
                        acc_r <= acc_r;
                    end
                    if (idx_r == LAST_IDX) begin
                        state_r <= ST_DRAIN;
                    end else begin
                        state_r <= ST_SHIFT;
                    end
                end
                ST_DRAIN: begin
                    // last sample belongs to bit WIDTH-1; publish on DONE entry
                    if (bus.det_y) begin
                        acc_r  <= acc_r + CNT_W'(1);
                        hits_r <= acc_r + CNT_W'(1);
                    end else begin
                        hits_r <= acc_r;
                    end
                    done_id_r <= id_r;
                    state_r   <= ST_DONE;
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.gnt0      = gnt0_s;
    assign bus.gnt1      = gnt1_s;
    assign bus.busy      = busy_s;
    assign bus.done      = done_s;
    assign bus.det_x     = det_x_s;
    assign bus.det_clr_n = det_clr_n_s;
    assign bus.hits      = hits_r;
    assign bus.done_id   = done_id_r;
endmodule
